alu_seq16: RTL and testbench
============================

ALU_SEQ16 -- requirements
Module: alu_seq16

Interface
REQ-001 SHALL have port CLK  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port RESET_N  input  1  reset, synchronous and active-low.
REQ-003 SHALL have port START  input  1  request; accepted only when BUSY=0.
REQ-004 SHALL have port OP  input  3  opcode from shared package: kADD, kRSH, kXOR, kAND; other codes treated as NOP.
REQ-005 SHALL have ports A, B  input  16  operands, captured on accept.
REQ-006 SHALL have port SHAMT  input  4  right-shift count 0..15 (kRSH only), captured on accept.
REQ-007 SHALL have port CIN  input  1  carry-in for kADD, captured on accept.
REQ-008 SHALL have port BUSY  output  1  high from cycle after accept until DONE cycle inclusive.
REQ-009 SHALL have port DONE  output  1  one-cycle pulse; RESULT/COUT/ZERO valid from this cycle.
REQ-010 SHALL have ports RESULT  output  16, COUT  output  1, ZERO  output  1 (RESULT==0); registered, held until next DONE.

Function
REQ-011 SHALL perform 16-bit operations by sequencing one 8-bit ALU instance, one byte per cycle.
REQ-012 SHALL implement FSM states IDLE, LSW, MSW, FIN; FIN asserts DONE and returns to IDLE.
REQ-013 SHALL, in IDLE with START=1, latch OP/A/B/SHAMT/CIN into working registers and set BUSY next cycle.
REQ-014 SHALL ignore START and all operand inputs while BUSY=1.
REQ-015 SHALL for kADD: IDLE->LSW (SC_IN=CIN)->MSW (SC_IN=LSW carry-out)->FIN; COUT = MSW carry-out; DONE 3 cycles after accept edge.
REQ-016 SHALL for kXOR/kAND/NOP: same LSW->MSW->FIN path; COUT=0; NOP yields RESULT=0, ZERO=1.
REQ-017 SHALL for kRSH (logical): per bit, MSW step (SC_IN=0, carry-out = MSW bit0) then LSW step (SC_IN = that carry); repeat SHAMT times via 4-bit down-counter; then FIN.
REQ-018 SHALL for kRSH set COUT = bit shifted out of LSW in final iteration; DONE 2*SHAMT+1 cycles after accept edge.
REQ-019 SHALL for kRSH with SHAMT=0 go IDLE->FIN directly: RESULT=A, COUT=0, DONE 1 cycle after accept.
REQ-020 SHALL write each ALU byte result back into the 16-bit working register the cycle it is computed; carry held in a 1-bit register between steps.
REQ-021 SHALL update RESULT/COUT/ZERO only on entry to FIN; never mid-sequence.
REQ-022 SHALL permit START in the cycle immediately after DONE (back-to-back, no dead cycle beyond IDLE).

Reset
REQ-023 SHALL, when RESET_N=0 at a rising edge, force state IDLE, BUSY=0, DONE=0, RESULT=0, COUT=0, ZERO=0, counter=0, carry=0.
REQ-024 SHALL abort any in-flight operation on reset with no DONE pulse and no partial result visible.
REQ-025 SHALL ignore START in a cycle where RESET_N=0.

Structure
REQ-026 SHALL take opcode enum (kADD, kRSH, kXOR, kAND) from package definitions; FSM state enum also defined there.
REQ-027 SHALL instantiate exactly one sub-module, the existing combinational ALU, driving INPUTA/INPUTB/OP/SC_IN per step; its ZERO output unused.
REQ-028 SHALL keep all sequential logic in one always_ff block with synchronous reset; next-state/mux in always_comb.

Verification
REQ-029 SHALL cover: kADD A=0x00FF B=0x0001 CIN=0 -> RESULT=0x0100, COUT=0, ZERO=0, DONE 3 cycles after accept.
REQ-030 SHALL cover: kADD A=0xFFFF B=0x0001 CIN=0 -> RESULT=0x0000, COUT=1, ZERO=1; and A=0x0000 B=0x0000 CIN=1 -> 0x0001, COUT=0.
REQ-031 SHALL cover: kRSH A=0x8001 SHAMT=1 -> 0x4000, COUT=1, DONE 3 cycles after accept; A=0x1234 SHAMT=4 -> 0x0123, COUT=0, DONE 9 cycles after.
REQ-032 SHALL cover: kRSH A=0xBEEF SHAMT=0 -> RESULT=0xBEEF, COUT=0, DONE 1 cycle after accept.
REQ-033 SHALL cover: kXOR 0xA5A5^0xA5A5 with START re-asserted and A changed while BUSY -> RESULT=0x0000, ZERO=1, second START ignored.
REQ-034 SHALL cover: RESET_N=0 during MSW of kADD -> next cycle BUSY=0, no DONE, RESULT=0; fresh kAND 0xF0F0&0x0FF0 after -> 0x00F0.

Source files
------------

// File: rtl/alu_seq16_pkg.sv
// Shared definitions for the byte-sequenced 16-bit ALU: widths, opcodes and
// the controller state encoding.
package alu_seq16_pkg;

    localparam int unsigned WORD_W  = 16;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned OP_W    = 3;
    localparam int unsigned SHAMT_W = 4;

    // Codes outside this set are executed as NOP by the byte ALU.
    typedef enum logic [OP_W-1:0] {
        kADD = 3'd0,
        kRSH = 3'd1,
        kXOR = 3'd2,
        kAND = 3'd3
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        LSW,
        MSW,
        FIN
    } state_e;

endpackage

// File: rtl/alu_seq16_alu8.sv
// Combinational 8-bit ALU slice. SC_IN/SC_OUT carry the add carry or the bit
// moved between bytes by a one-position logical right shift.
module alu_seq16_alu8
    import alu_seq16_pkg::*;
(
    input  logic [BYTE_W-1:0] INPUTA,
    input  logic [BYTE_W-1:0] INPUTB,
    input  logic [OP_W-1:0]   OP,
    input  logic              SC_IN,
    output logic [BYTE_W-1:0] RESULT,
    output logic              SC_OUT,
    output logic              ZERO
);

    logic [BYTE_W:0] sum;

    assign sum = {1'b0, INPUTA} + {1'b0, INPUTB} + {{BYTE_W{1'b0}}, SC_IN};

    always_comb begin
        // NOTE: every output gets a default first so no path through the case can infer a latch.
        RESULT = '0;
        SC_OUT = 1'b0;
        case (OP)
            kADD: {SC_OUT, RESULT} = sum;
            kRSH: begin
                RESULT = {SC_IN, INPUTA[BYTE_W-1:1]};
                SC_OUT = INPUTA[0];
            end
            kXOR:    RESULT = INPUTA ^ INPUTB;
            kAND:    RESULT = INPUTA & INPUTB;
            default: RESULT = '0;
        endcase
    end

    assign ZERO = (RESULT == '0);

endmodule

// File: rtl/alu_seq16.sv
// 16-bit ALU built by stepping one 8-bit ALU slice over the low and high bytes
// of a working register; right shifts repeat an MSW->LSW pair per bit.
module alu_seq16
    import alu_seq16_pkg::*;
(
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               START,
    input  logic [OP_W-1:0]    OP,
    input  logic [WORD_W-1:0]  A,
    input  logic [WORD_W-1:0]  B,
    input  logic [SHAMT_W-1:0] SHAMT,
    input  logic               CIN,
    output logic               BUSY,
    output logic               DONE,
    output logic [WORD_W-1:0]  RESULT,
    output logic               COUT,
    output logic               ZERO
);

    state_e             state_q, state_d;
    logic [OP_W-1:0]    op_q, op_d;
    logic [WORD_W-1:0]  work_q, work_d;
    logic [WORD_W-1:0]  b_q, b_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic [WORD_W-1:0]  result_q;
    logic               cout_q, zero_q;

    logic [BYTE_W-1:0]  alu_a, alu_b, alu_res;
    logic               alu_sc_in, alu_sc_out, alu_zero_unused;
    logic               is_rsh;

    assign is_rsh = (op_q == kRSH);

    alu_seq16_alu8 u_alu8 (
        .INPUTA (alu_a),
        .INPUTB (alu_b),
        .OP     (op_q),
        .SC_IN  (alu_sc_in),
        .RESULT (alu_res),
        .SC_OUT (alu_sc_out),
        .ZERO   (alu_zero_unused)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        work_d    = work_q;
        b_d       = b_q;
        cnt_d     = cnt_q;
        carry_d   = carry_q;
        alu_a     = work_q[BYTE_W-1:0];
        alu_b     = b_q[BYTE_W-1:0];
        alu_sc_in = carry_q;

        case (state_q)
            IDLE: begin
                if (START) begin
                    op_d    = OP;
                    work_d  = A;
                    b_d     = B;
                    cnt_d   = SHAMT;
                    // The carry register doubles as the add carry-in for the first byte.
                    carry_d = (OP == kADD) ? CIN : 1'b0;
                    if (OP == kRSH) begin
                        state_d = (SHAMT == '0) ? FIN : MSW;
                    end else begin
                        state_d = LSW;
                    end
                end
            end
            LSW: begin
                work_d[BYTE_W-1:0] = alu_res;
                carry_d            = alu_sc_out;
                if (is_rsh) begin
                    cnt_d   = cnt_q - 1'b1;
                    state_d = (cnt_q == 1) ? FIN : MSW;
                end else begin
                    state_d = MSW;
                end
            end
            MSW: begin
                alu_a                   = work_q[WORD_W-1:BYTE_W];
                alu_b                   = b_q[WORD_W-1:BYTE_W];
                alu_sc_in               = is_rsh ? 1'b0 : carry_q;
                work_d[WORD_W-1:BYTE_W] = alu_res;
                carry_d                 = alu_sc_out;
                state_d                 = is_rsh ? LSW : FIN;
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q  <= IDLE;
            op_q     <= '0;
            work_q   <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            op_q    <= op_d;
            work_q  <= work_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            // Outputs change only when the sequence completes.
            if (state_d == FIN) begin
                result_q <= work_d;
                cout_q   <= carry_d;
                zero_q   <= (work_d == '0);
            end
        end
    end

    assign BUSY   = (state_q != IDLE);
    assign DONE   = (state_q == FIN);
    assign RESULT = result_q;
    assign COUT   = cout_q;
    assign ZERO   = zero_q;

endmodule

// File: tb/tb_alu_seq16.sv
// Self-checking bench for alu_seq16: directed corner cases plus randomized
// back-to-back operations against a word-level arithmetic model.
module tb_alu_seq16;
    import alu_seq16_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        START;
    logic [2:0]  OP;
    logic [15:0] A, B;
    logic [3:0]  SHAMT;
    logic        CIN;
    logic        BUSY, DONE, COUT, ZERO;
    logic [15:0] RESULT;

    int n_tests = 0;
    int n_fail  = 0;

    alu_seq16 dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .START   (START),
        .OP      (OP),
        .A       (A),
        .B       (B),
        .SHAMT   (SHAMT),
        .CIN     (CIN),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .RESULT  (RESULT),
        .COUT    (COUT),
        .ZERO    (ZERO)
    );

    always #5 CLK = ~CLK;

    // Word-level reference: result, carry-out and DONE latency from accept edge.
    function automatic void model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                  input logic [3:0] sh, input logic cin,
                                  output logic [15:0] r, output logic co, output int lat);
        r   = 16'h0;
        co  = 1'b0;
        lat = 3;
        case (op)
            3'd0: {co, r} = {1'b0, a} + {1'b0, b} + {16'h0, cin};
            3'd1: begin
                r   = a >> sh;
                co  = (sh == 4'd0) ? 1'b0 : a[sh - 4'd1];
                lat = 2 * int'(sh) + 1;
            end
            3'd2:    r = a ^ b;
            3'd3:    r = a & b;
            default: r = 16'h0;
        endcase
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Issues one operation and waits (bounded) for DONE. With spam set, START
    // stays high with garbage operands while the DUT is busy.
    task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] sh, input logic cin, input bit spam,
                          output logic [15:0] res, output logic co, output logic z,
                          output int lat, output bit busy_ok, output bit held_ok);
        logic [17:0] prev;
        if (DONE === 1'b1) tick();
        prev  = {RESULT, COUT, ZERO};
        OP    = op;
        A     = a;
        B     = b;
        SHAMT = sh;
        CIN   = cin;
        START = 1'b1;
        tick();
        busy_ok = (BUSY === 1'b1);
        START   = spam;
        OP      = 3'($urandom);
        A       = ~a;
        B       = 16'($urandom);
        SHAMT   = ~sh;
        CIN     = ~cin;
        held_ok = 1'b1;
        lat     = 1;
        while (DONE !== 1'b1 && lat < 64) begin
            if ({RESULT, COUT, ZERO} !== prev) held_ok = 1'b0;
            tick();
            lat++;
        end
        START = 1'b0;
        res   = RESULT;
        co    = COUT;
        z     = ZERO;
    endtask

    task automatic test_reset();
        RESET_N = 1'b0;
        START   = 1'b1;
        OP      = kADD;
        A       = 16'h0001;
        B       = 16'h0001;
        SHAMT   = 4'd0;
        CIN     = 1'b1;
        repeat (3) tick();
        n_tests++;
        if ({BUSY, DONE} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_ctrl: busy/done=%b required 00", {BUSY, DONE});
        end
        n_tests++;
        if ({RESULT, COUT, ZERO} !== 18'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: result=%h cout=%b zero=%b required 0000/0/0", RESULT, COUT, ZERO);
        end
        START   = 1'b0;
        RESET_N = 1'b1;
        tick();
        n_tests++;
        if (BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_start_ignored: busy=%b required 0", BUSY);
        end
    endtask

    task automatic test_add();
        logic [15:0] ta[3] = '{16'h00FF, 16'hFFFF, 16'h0000};
        logic [15:0] tb[3] = '{16'h0001, 16'h0001, 16'h0000};
        logic        tc[3] = '{1'b0, 1'b0, 1'b1};
        logic [15:0] er[3] = '{16'h0100, 16'h0000, 16'h0001};
        logic        ec[3] = '{1'b0, 1'b1, 1'b0};
        logic        ez[3] = '{1'b0, 1'b1, 1'b0};
        logic [15:0] res;
        logic        co, z;
        int          lat;
        bit          busy_ok, held_ok;
        for (int i = 0; i < 3; i++) begin
            run_op(kADD, ta[i], tb[i], 4'd0, tc[i], 1'b0, res, co, z, lat, busy_ok, held_ok);
            n_tests++;
            if ({res, co, z} !== {er[i], ec[i], ez[i]}) begin
                n_fail++;
                $display("FAIL add_result %h+%h+%b: got %h/%b/%b required %h/%b/%b",
                         ta[i], tb[i], tc[i], res, co, z, er[i], ec[i], ez[i]);
            end
            n_tests++;
            if (lat !== 3 || !busy_ok || !held_ok) begin
                n_fail++;
                $display("FAIL add_timing %h+%h: latency=%0d busy=%b held=%b required 3/1/1",
                         ta[i], tb[i], lat, busy_ok, held_ok);
            end
        end
    endtask

    task automatic test_rsh();
        logic [15:0] ta[4] = '{16'h8001, 16'h1234, 16'hBEEF, 16'hFFFF};
        logic [3:0]  ts[4] = '{4'd1, 4'd4, 4'd0, 4'd15};
        logic [15:0] er[4] = '{16'h4000, 16'h0123, 16'hBEEF, 16'h0001};
        logic        ec[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int          el[4] = '{3, 9, 1, 31};
        logic [15:0] res;
        logic        co, z;
        int          lat;
        bit          busy_ok, held_ok;
        for (int i = 0; i < 4; i++) begin
            run_op(kRSH, ta[i], 16'h5A5A, ts[i], 1'b1, 1'b0, res, co, z, lat, busy_ok, held_ok);
            n_tests++;
            if ({res, co, z} !== {er[i], ec[i], 1'b0}) begin
                n_fail++;
                $display("FAIL rsh_result %h>>%0d: got %h/%b/%b required %h/%b/0",
                         ta[i], ts[i], res, co, z, er[i], ec[i]);
            end
            n_tests++;
            if (lat !== el[i] || !busy_ok || !held_ok) begin
                n_fail++;
                $display("FAIL rsh_timing %h>>%0d: latency=%0d busy=%b held=%b required %0d/1/1",
                         ta[i], ts[i], lat, busy_ok, held_ok, el[i]);
            end
        end
    endtask

    task automatic test_xor_busy();
        logic [15:0] res;
        logic        co, z;
        int          lat;
        bit          busy_ok, held_ok;
        run_op(kXOR, 16'hA5A5, 16'hA5A5, 4'd3, 1'b1, 1'b1, res, co, z, lat, busy_ok, held_ok);
        n_tests++;
        if ({res, co, z, lat} !== {16'h0000, 1'b0, 1'b1, 32'sd3}) begin
            n_fail++;
            $display("FAIL xor_busy_result: got %h/%b/%b lat=%0d required 0000/0/1 lat=3", res, co, z, lat);
        end
        tick();
        n_tests++;
        if ({BUSY, DONE} !== 2'b00) begin
            n_fail++;
            $display("FAIL xor_busy_restart: busy/done=%b required 00", {BUSY, DONE});
        end
    endtask

    task automatic test_reset_abort();
        logic [15:0] res;
        logic        co, z;
        int          lat;
        bit          busy_ok, held_ok, saw_done;
        run_op(kADD, 16'h1000, 16'h0234, 4'd0, 1'b0, 1'b0, res, co, z, lat, busy_ok, held_ok);
        tick();
        OP    = kADD;
        A     = 16'hFFFF;
        B     = 16'h0003;
        CIN   = 1'b1;
        START = 1'b1;
        tick();
        START = 1'b0;
        tick();
        RESET_N = 1'b0;
        tick();
        RESET_N = 1'b1;
        n_tests++;
        if ({BUSY, DONE, RESULT, COUT, ZERO} !== 20'h0) begin
            n_fail++;
            $display("FAIL abort_state: busy=%b done=%b result=%h cout=%b zero=%b required all 0",
                     BUSY, DONE, RESULT, COUT, ZERO);
        end
        saw_done = 1'b0;
        repeat (4) begin
            tick();
            if (DONE !== 1'b0 || BUSY !== 1'b0) saw_done = 1'b1;
        end
        n_tests++;
        if (saw_done) begin
            n_fail++;
            $display("FAIL abort_quiet: activity=1 required 0 after reset");
        end
        run_op(kAND, 16'hF0F0, 16'h0FF0, 4'd0, 1'b0, 1'b0, res, co, z, lat, busy_ok, held_ok);
        n_tests++;
        if ({res, co, z, lat} !== {16'h00F0, 1'b0, 1'b0, 32'sd3}) begin
            n_fail++;
            $display("FAIL abort_then_and: got %h/%b/%b lat=%0d required 00F0/0/0 lat=3", res, co, z, lat);
        end
    endtask

    // Consecutive operations with no idle cycles beyond the mandatory IDLE.
    task automatic test_back_to_back(input int n_ops, input bit gaps);
        logic [2:0]  op;
        logic [15:0] a, b, er, res;
        logic [3:0]  sh;
        logic        cin, ec, co, z;
        int          el, lat;
        bit          busy_ok, held_ok;
        for (int i = 0; i < n_ops; i++) begin
            op  = 3'($urandom_range(0, 7));
            a   = 16'($urandom);
            b   = 16'($urandom);
            sh  = 4'($urandom);
            cin = 1'($urandom);
            if ($urandom_range(0, 5) == 0) b = -a;
            model(op, a, b, sh, cin, er, ec, el);
            if (gaps) repeat ($urandom_range(0, 2)) tick();
            run_op(op, a, b, sh, cin, gaps && 1'($urandom), res, co, z, lat, busy_ok, held_ok);
            n_tests++;
            if ({res, co, z} !== {er, ec, (er == 16'h0)}) begin
                n_fail++;
                $display("FAIL rand_result op=%0d a=%h b=%h sh=%0d cin=%b: got %h/%b/%b required %h/%b/%b",
                         op, a, b, sh, cin, res, co, z, er, ec, (er == 16'h0));
            end
            n_tests++;
            if (lat !== el || !busy_ok || !held_ok) begin
                n_fail++;
                $display("FAIL rand_timing op=%0d sh=%0d: latency=%0d busy=%b held=%b required %0d/1/1",
                         op, sh, lat, busy_ok, held_ok, el);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_rsh();
        test_xor_busy();
        test_reset_abort();
        test_back_to_back(8, 1'b0);
        test_back_to_back(40, 1'b1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
